// File: rtl/uart_cmd_pkg.sv
// Shared command, status and framing constants for the UART register bank
// and its response serialiser.
package uart_cmd_pkg;

    localparam logic [7:0] FN_HS_WR  = 8'h01;
    localparam logic [7:0] FN_LS_WR  = 8'h02;
    localparam logic [7:0] FN_COMMIT = 8'h03;
    localparam logic [7:0] FN_READ   = 8'h04;
    localparam logic [7:0] FN_STOP   = 8'h05;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BAD_CH = 8'h01;
    localparam logic [7:0] ST_BAD_FN = 8'h02;

    localparam logic [7:0] RESP_HDR  = 8'hA5;
    localparam logic [3:0] ACK_LEN   = 4'd4;
    localparam logic [3:0] READ_LEN  = 4'd15;

    // Bits of hs_ctrl cleared by the global stop (PWM enable, DAC enable).
    localparam logic [7:0] STOP_MASK = 8'h09;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [7:0]  duty;
        logic [15:0] dessert;
        logic [7:0]  pnum;
        logic [31:0] pat;
    } hs_set_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Response frame serialiser: latches header/payload, streams bytes over a
// valid/ready handshake and appends the running XOR checksum as the last byte.
module uart_resp_tx
    import uart_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  func,
    input  logic [7:0]  status,
    input  logic [87:0] data_bytes,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    resp_state_t state_reg, state_next;
    logic [7:0]  frame_reg [0:13];
    logic [3:0]  idx_reg;
    logic [3:0]  len_reg;
    logic [7:0]  chk_reg;
    logic        last_byte;

    assign last_byte = (idx_reg == len_reg - 4'd1);
    assign tx_valid  = (state_reg == S_SEND);
    assign busy      = (state_reg != S_IDLE);

    always_comb begin
        tx_data = 8'h00;
        if (last_byte)
            tx_data = chk_reg;
        else if (idx_reg < 4'd14)
            tx_data = frame_reg[idx_reg];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_SEND;
            S_SEND:  if (tx_ready && last_byte) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 14; k++) frame_reg[k] <= 8'h00;
            idx_reg <= 4'd0;
            len_reg <= ACK_LEN;
            chk_reg <= 8'h00;
        end else if (state_reg == S_LOAD) begin
            frame_reg[0] <= RESP_HDR;
            frame_reg[1] <= func;
            frame_reg[2] <= status;
            for (int k = 0; k < 11; k++) frame_reg[3 + k] <= data_bytes[8*k +: 8];
            len_reg <= (func == FN_READ && status == ST_OK) ? READ_LEN : ACK_LEN;
            idx_reg <= 4'd0;
            chk_reg <= 8'h00;
        end else if (state_reg == S_SEND && tx_ready) begin
            idx_reg <= idx_reg + 4'd1;
            chk_reg <= chk_reg ^ tx_data;
        end
    end

endmodule

// File: rtl/uart_reg_bank.sv
// Decodes UART command packets into double-buffered per-channel HS register
// sets plus direct LS registers; every accepted packet produces a response frame.
module uart_reg_bank
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int PAT_WIDTH = 32,
    parameter int DROP_W    = 8
) (
    input  logic                        clk_50M,
    input  logic                        rst,
    input  logic [7:0]                  func_reg,
    input  logic [87:0]                 rx_payload,
    input  logic                        pack_done,
    output logic [8*NUM_CH-1:0]         hs_ctrl_flat,
    output logic [8*NUM_CH-1:0]         duty_flat,
    output logic [16*NUM_CH-1:0]        dessert_flat,
    output logic [8*NUM_CH-1:0]         pnum_flat,
    output logic [PAT_WIDTH*NUM_CH-1:0] pat_flat,
    output logic [8*NUM_CH-1:0]         ls_ctrl_flat,
    output logic [NUM_CH-1:0]           commit_pulse,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        resp_busy,
    output logic [DROP_W-1:0]           drop_cnt
);

    localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [32:0] PAT_MASK = (33'd1 << PAT_WIDTH) - 33'd1;

    logic [7:0]        pl [1:11];
    logic [7:0]        ch;
    logic              accept;
    logic              ch_ok;
    logic [7:0]        status;
    logic              wr_ok;
    logic              hs_commit;
    hs_set_t           hs_new;
    hs_set_t           active_arr [NUM_CH];
    logic [7:0]        ls_arr     [NUM_CH];
    logic [7:0]        req_func_reg, req_status_reg, req_ch_reg;
    logic [DROP_W-1:0] drop_cnt_reg;
    hs_set_t           snap;
    logic [87:0]       snap_bytes;

    for (genvar gi = 1; gi <= 11; gi++) begin : g_pl
        assign pl[gi] = rx_payload[8*gi-1 -: 8];
    end

    assign ch        = pl[1];
    assign accept    = pack_done && !resp_busy;
    assign ch_ok     = ({24'd0, ch} < 32'(NUM_CH));
    assign hs_commit = ((pl[11] & 8'h01) != 8'h00);
    assign hs_new    = '{ctrl: pl[2], duty: pl[3], dessert: {pl[4], pl[5]}, pnum: pl[6],
                         pat: {pl[7], pl[8], pl[9], pl[10]} & PAT_MASK[31:0]};

    always_comb begin
        status = ST_BAD_FN;
        case (func_reg)
            FN_HS_WR, FN_LS_WR, FN_READ: status = ch_ok ? ST_OK : ST_BAD_CH;
            FN_COMMIT, FN_STOP:          status = ST_OK;
            default:                     status = ST_BAD_FN;
        endcase
    end

    assign wr_ok = accept && (status == ST_OK);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        hs_set_t    shadow_reg, active_reg;
        logic [7:0] ls_reg;
        logic       pulse_reg;
        logic       hs_wr, ls_wr, commit_now, stop_now;

        assign hs_wr      = wr_ok && func_reg == FN_HS_WR && ch == 8'(gi);
        assign ls_wr      = wr_ok && func_reg == FN_LS_WR && ch == 8'(gi);
        assign stop_now   = accept && func_reg == FN_STOP;
        // The commit mask occupies payload bytes 1..4, i.e. rx_payload[31:0].
        assign commit_now = (accept && func_reg == FN_COMMIT && rx_payload[gi])
                         || (hs_wr && hs_commit);

        always_ff @(posedge clk_50M or posedge rst) begin
            if (rst) begin
                shadow_reg <= '0;
                active_reg <= '0;
                ls_reg     <= 8'h00;
                pulse_reg  <= 1'b0;
            end else begin
                pulse_reg <= commit_now || stop_now;
                if (hs_wr)
                    shadow_reg <= hs_new;
                else if (stop_now)
                    shadow_reg.ctrl <= shadow_reg.ctrl & ~STOP_MASK;
                // A write-and-commit must publish the new data, not the old shadow.
                if (commit_now)
                    active_reg <= hs_wr ? hs_new : shadow_reg;
                else if (stop_now)
                    active_reg.ctrl <= active_reg.ctrl & ~STOP_MASK;
                if (ls_wr)
                    ls_reg <= pl[2];
            end
        end

        assign active_arr[gi]                        = active_reg;
        assign ls_arr[gi]                            = ls_reg;
        assign commit_pulse[gi]                      = pulse_reg;
        assign hs_ctrl_flat[8*gi +: 8]               = active_reg.ctrl;
        assign duty_flat[8*gi +: 8]                  = active_reg.duty;
        assign dessert_flat[16*gi +: 16]             = active_reg.dessert;
        assign pnum_flat[8*gi +: 8]                  = active_reg.pnum;
        assign pat_flat[PAT_WIDTH*gi +: PAT_WIDTH]   = active_reg.pat[PAT_WIDTH-1:0];
        assign ls_ctrl_flat[8*gi +: 8]               = ls_reg;
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            req_func_reg   <= 8'h00;
            req_status_reg <= 8'h00;
            req_ch_reg     <= 8'h00;
            drop_cnt_reg   <= '0;
        end else begin
            if (accept) begin
                req_func_reg   <= func_reg;
                req_status_reg <= status;
                req_ch_reg     <= ch;
            end
            if (pack_done && resp_busy && drop_cnt_reg != '1)
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;

    // Snapshot is taken by the serialiser in its LOAD cycle, after any update.
    assign snap       = active_arr[req_ch_reg[CH_W-1:0]];
    assign snap_bytes = {ls_arr[req_ch_reg[CH_W-1:0]], snap.pat[7:0], snap.pat[15:8],
                         snap.pat[23:16], snap.pat[31:24], snap.pnum, snap.dessert[7:0],
                         snap.dessert[15:8], snap.duty, snap.ctrl, req_ch_reg};

    uart_resp_tx u_resp_tx (
        .clk        (clk_50M),
        .rst        (rst),
        .start      (accept),
        .func       (req_func_reg),
        .status     (req_status_reg),
        .data_bytes (snap_bytes),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (resp_busy)
    );

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank: command decode, commit pulses, response
// frames with ready back-pressure, drop counting and asynchronous reset.
module tb_uart_reg_bank;

    logic         clk_50M = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   func_reg = 8'h00;
    logic [87:0]  rx_payload = '0;
    logic         pack_done = 1'b0;
    logic [63:0]  hs_ctrl_flat, duty_flat, pnum_flat, ls_ctrl_flat;
    logic [127:0] dessert_flat;
    logic [255:0] pat_flat;
    logic [7:0]   commit_pulse;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         resp_busy;
    logic [7:0]   drop_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0] e [15];

    uart_reg_bank #(.NUM_CH(8), .PAT_WIDTH(32), .DROP_W(8)) dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .func_reg     (func_reg),
        .rx_payload   (rx_payload),
        .pack_done    (pack_done),
        .hs_ctrl_flat (hs_ctrl_flat),
        .duty_flat    (duty_flat),
        .dessert_flat (dessert_flat),
        .pnum_flat    (pnum_flat),
        .pat_flat     (pat_flat),
        .ls_ctrl_flat (ls_ctrl_flat),
        .commit_pulse (commit_pulse),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .resp_busy    (resp_busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1 of cycle T+1.
    task automatic send_pkt(input logic [7:0] f, input logic [87:0] p);
        func_reg   = f;
        rx_payload = p;
        pack_done  = 1'b1;
        @(posedge clk_50M); #1;
        pack_done  = 1'b0;
        $display("pkt func=%h payload=%h", f, p);
    endtask

    // Receives n bytes against e[]; toggle alternates tx_ready, inject_last
    // raises pack_done in the cycle the final byte is accepted.
    task automatic collect(input int n, input bit toggle, input bit inject_last, input string tag);
        int         got = 0;
        int         cyc = 0;
        bit         holding = 0;
        logic [7:0] held = 8'h00;
        while (got < n && cyc < 200) begin
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (holding && tx_valid) check({tag, " hold"}, tx_data, held);
            if (tx_valid && tx_ready) begin
                check($sformatf("%s byte%0d", tag, got), tx_data, e[got]);
                if (inject_last && got == n - 1) begin
                    func_reg   = 8'h01;
                    rx_payload = {8'h01, 32'h0, 8'h00, 16'h0, 8'h99, 8'h01, 8'h02};
                    pack_done  = 1'b1;
                end
                got++;
                holding = 0;
            end else if (tx_valid) begin
                held    = tx_data;
                holding = 1;
            end
            @(posedge clk_50M); #1;
            pack_done = 1'b0;
            cyc++;
        end
        tx_ready = 1'b0;
        if (got < n) check({tag, " timeout"}, 64'(got), 64'(n));
        check({tag, " idle"}, {62'd0, tx_valid, resp_busy}, 64'd0);
        $display("frame %s: %0d bytes in %0d cycles", tag, got, cyc);
    endtask

    task automatic ack(input logic [7:0] f, input logic [7:0] s, input logic [7:0] c, input string tag);
        e[0] = 8'hA5; e[1] = f; e[2] = s; e[3] = c;
        collect(4, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #12;
        check("rst tx_valid", tx_valid, 0);
        check("rst busy", resp_busy, 0);
        check("rst flats", |{hs_ctrl_flat, duty_flat, dessert_flat, pnum_flat, pat_flat,
                             ls_ctrl_flat, commit_pulse, drop_cnt}, 0);
        @(posedge clk_50M); #1;
        rst = 1'b0;
        @(posedge clk_50M); #1;

        // HS write to ch2 without commit: only the shadow changes.
        send_pkt(8'h01, {8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h05, 8'h20, 8'h00, 8'h10, 8'h01, 8'h02});
        check("hs nocommit duty2", duty_flat[23:16], 8'h00);
        check("hs nocommit pulse", commit_pulse, 8'h00);
        ack(8'h01, 8'h00, 8'hA4, "ack_hs");

        // Commit ch2 only.
        send_pkt(8'h03, {56'h0, 32'h0000_0004});
        check("commit pulse", commit_pulse, 8'h04);
        check("commit ctrl2", hs_ctrl_flat[23:16], 8'h01);
        check("commit duty2", duty_flat[23:16], 8'h10);
        check("commit dessert2", dessert_flat[47:32], 16'h0020);
        check("commit pnum2", pnum_flat[23:16], 8'h05);
        check("commit pat2", pat_flat[95:64], 32'hDEADBEEF);
        @(posedge clk_50M); #1;
        check("commit pulse gone", commit_pulse, 8'h00);
        ack(8'h03, 8'h00, 8'hA6, "ack_commit");

        // Readback ch2 under alternating back-pressure.
        send_pkt(8'h04, {80'h0, 8'h02});
        e = '{8'hA5, 8'h04, 8'h00, 8'h02, 8'h01, 8'h10, 8'h00, 8'h20,
              8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'hB5};
        collect(15, 1'b1, 1'b0, "rb1");

        // Bad channel and unknown function.
        send_pkt(8'h01, {80'h0, 8'h08});
        check("badch ctrl", hs_ctrl_flat, 64'h0000_0000_0001_0000);
        ack(8'h01, 8'h01, 8'hA5, "ack_badch");
        send_pkt(8'h7F, 88'h0);
        ack(8'h7F, 8'h02, 8'hD8, "ack_badfn");

        // HS write ch0 with immediate commit.
        send_pkt(8'h01, {8'h01, 8'h04, 8'h03, 8'h02, 8'h01, 8'h07, 8'h34, 8'h12, 8'h33, 8'h09, 8'h00});
        check("wrc pulse", commit_pulse, 8'h01);
        check("wrc ctrl0", hs_ctrl_flat[7:0], 8'h09);
        check("wrc dessert0", dessert_flat[15:0], 16'h1234);
        check("wrc pat0", pat_flat[31:0], 32'h01020304);
        ack(8'h01, 8'h00, 8'hA4, "ack_wrc");

        // LS write ch5.
        send_pkt(8'h02, {72'h0, 8'h3C, 8'h05});
        check("ls ch5", ls_ctrl_flat, 64'h0000_3C00_0000_0000);
        check("ls pulse", commit_pulse, 8'h00);
        ack(8'h02, 8'h00, 8'hA7, "ack_ls");

        // Global stop clears enables everywhere and pulses all channels.
        send_pkt(8'h05, 88'h0);
        check("stop pulse", commit_pulse, 8'hFF);
        check("stop ctrl", hs_ctrl_flat, 64'h0);
        check("stop duty0 kept", duty_flat[7:0], 8'h33);
        ack(8'h05, 8'h00, 8'hA0, "ack_stop");

        // Two packets dropped during a stalled readback, a third on the last byte.
        send_pkt(8'h04, {80'h0, 8'h02});
        repeat (2) begin
            func_reg   = 8'h01;
            rx_payload = {8'h01, 32'h0, 8'h00, 16'h0, 8'h99, 8'h01, 8'h02};
            pack_done  = 1'b1;
            @(posedge clk_50M); #1;
            pack_done  = 1'b0;
        end
        check("drop cnt2", drop_cnt, 8'd2);
        check("drop duty2", duty_flat[23:16], 8'h10);
        check("drop pulse", commit_pulse, 8'h00);
        e = '{8'hA5, 8'h04, 8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h20,
              8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'hB4};
        collect(15, 1'b0, 1'b1, "rb2");
        check("drop last byte", drop_cnt, 8'd3);
        check("drop last duty2", duty_flat[23:16], 8'h10);

        // Saturation of the drop counter.
        send_pkt(8'h04, {80'h0, 8'h02});
        func_reg  = 8'h7F;
        pack_done = 1'b1;
        repeat (260) @(posedge clk_50M);
        #1;
        pack_done = 1'b0;
        check("drop sat", drop_cnt, 8'hFF);
        collect(15, 1'b0, 1'b0, "rb3");

        // Asynchronous reset in the middle of a frame.
        send_pkt(8'h04, {80'h0, 8'h02});
        @(posedge clk_50M); #1;
        check("pre-rst valid", tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst valid", tx_valid, 0);
        check("async rst busy", resp_busy, 0);
        check("async rst flats", |{hs_ctrl_flat, duty_flat, dessert_flat, pnum_flat, pat_flat,
                                   ls_ctrl_flat, commit_pulse, drop_cnt}, 0);
        @(posedge clk_50M); #1;
        rst = 1'b0;
        @(posedge clk_50M); #1;

        send_pkt(8'h02, {72'h0, 8'h77, 8'h01});
        check("post-rst ls1", ls_ctrl_flat, 64'h0000_0000_0000_7700);
        ack(8'h02, 8'h00, 8'hA7, "ack_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_reg_bank.md
Name: uart_reg_bank

Overview:
- Parametrised successor to the UART register mapper for the PWM/DAC pattern engines.
- Decodes received UART command packets into per-channel register sets, with NUM_CH configurable.
- HS registers are double-buffered: writes land in a shadow copy, and a commit command transfers selected channels atomically to the active copy.
- Every packet gets an ack/readback frame, serialised byte-wise to the UART TX through a valid/ready handshake.

Parameters:
- NUM_CH, 8, number of channels (1..32); the last channel feeds the DAC pattern engine, the others feed PWM engines.
- PAT_WIDTH, 32, active PAT width (1..32); taken from the LSBs of the 4 received PAT bytes.
- DROP_W, 8, width of the saturating dropped-packet counter.

Ports:
- clk_50M  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- func_reg  in  8  packet function code.
- rx_payload  in  88  data bytes 1..11 of the received packet; byte n sits at [8n-1:8n-8].
- pack_done  in  1  one-cycle strobe; func_reg and rx_payload are valid in the same cycle.
- hs_ctrl_flat  out  8*NUM_CH  active HS control; bit0 is PWM enable, bit3 is DAC enable.
- duty_flat  out  8*NUM_CH  active duty_num.
- dessert_flat  out  16*NUM_CH  active pulse_dessert.
- pnum_flat  out  8*NUM_CH  active pulse_num.
- pat_flat  out  PAT_WIDTH*NUM_CH  active PAT.
- ls_ctrl_flat  out  8*NUM_CH  LS control.
- commit_pulse  out  NUM_CH  one-cycle strobe per channel when its active set changes.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  UART TX accepts the byte.
- resp_busy  out  1  response FSM not idle.
- drop_cnt  out  DROP_W  packets dropped while busy; saturates at all-ones.

Behaviour:
- Reset: all shadow/active registers, outputs, drop_cnt and FSM go to 0 / IDLE; tx_valid drops immediately, including mid-frame.
- Packet accepted only when pack_done=1 and FSM is IDLE.
- Otherwise the packet is dropped: no register change, no response, drop_cnt+1.
- Commands (ch = byte1; a register update takes effect at the edge after pack_done, T+1):
  - 0x01 HS write, ch<NUM_CH: shadow[ch] <= {ctrl=b2, duty=b3, dessert={b4,b5}, pnum=b6, PAT={b7,b8,b9,b10}[PAT_WIDTH-1:0]}.
    - If b11[0]=1, also commit that channel in the same cycle; active takes the new data.
  - 0x02 LS write, ch<NUM_CH: ls_ctrl[ch] <= b2. Written directly, no shadow.
  - 0x03 commit: mask = {b4,b3,b2,b1}; for each i<NUM_CH with mask[i]=1, active[i] <= shadow[i] and commit_pulse[i]=1 at T+1. Mask bits >= NUM_CH are ignored.
  - 0x04 readback, ch<NUM_CH: snapshot active[ch] and ls_ctrl[ch] at T+1. No register change.
  - 0x05 global stop: clear bit0 and bit3 of hs_ctrl in both active and shadow for all channels; commit_pulse all ones.
  - ch>=NUM_CH on 0x01/0x02/0x04: status 0x01, no write.
  - Any other func: status 0x02, no write.
- Response frame; checksum = XOR of all preceding bytes:
  - Ack (all commands except successful 0x04): A5, func, status, chk. 4 bytes.
  - Readback OK: A5, 04, 00, ch, hs_ctrl, duty, dessert[15:8], dessert[7:0], pnum, PAT[31:24..7:0] (4 bytes, zero-extended), ls_ctrl, chk. 15 bytes.
- FSM:
  - IDLE: on an accepted packet, go to LOAD.
  - LOAD (T+1): latch func, status, snapshot and frame length; byte index = 0.
  - SEND (from T+2): tx_valid=1; tx_data stays stable until tx_ready. On valid&ready, index+1 and XOR the byte into the checksum. After the last byte is accepted, go to IDLE.
- tx_valid never depends combinationally on tx_ready.
- Same-cycle tx_ready and pack_done on the last byte: the packet is dropped, because the FSM is not yet IDLE.
- commit_pulse is 0 in every cycle other than T+1 of a commit-causing packet.

Decomposition:
- Shared package uart_cmd_pkg:
  - function codes (FN_HS_WR=0x01, FN_LS_WR=0x02, FN_COMMIT=0x03, FN_READ=0x04, FN_STOP=0x05)
  - status codes (ST_OK=0x00, ST_BAD_CH=0x01, ST_BAD_FN=0x02)
  - RESP_HDR=0xA5, ACK_LEN=4, READ_LEN=15
  - FSM state encoding
- One sub-module, uart_resp_tx: byte-indexed frame serialiser with running checksum and valid/ready output. The bank holds only decode and registers.

Test Plan:
- 0x01 ch=2, b2..b10=01,10,00,20,05,DE,AD,BE,EF, b11=0 -> active[2] unchanged, no commit_pulse, ack A5 01 00 A4.
- 0x03 mask=00000004 after the above -> at T+1 active[2] = {01,10,0020,05,DEADBEEF}, commit_pulse=0x04 for one cycle, ack A5 03 00 A6.
- 0x04 ch=2 with tx_ready toggling 1/0 -> 15 bytes A5 04 00 02 01 10 00 20 05 DE AD BE EF 00 chk; each byte held while ready=0.
- 0x01 ch=NUM_CH -> no change, ack A5 01 01 A5; func 0x7F -> ack A5 7F 02 D8.
- Two pack_done during one 15-byte readback with tx_ready=0 -> drop_cnt=2, registers unchanged; after 255+ drops -> drop_cnt=FF.
- rst asserted mid-SEND -> tx_valid=0 asynchronously, all flat outputs 0; a packet after release is accepted normally.
